r2sdf_butterfly_stage_16b: RTL



---
 rtl/r2sdf_butterfly_stage_16b.sv | 63 ++++++
 1 files changed

// File: rtl/r2sdf_butterfly_stage_16b.sv
// r2sdf_butterfly_stage_16b: radix-2 single-path delay-feedback butterfly stage, one complex sample per valid cycle
module r2sdf_butterfly_stage_16b #(
  parameter int DELAY = 32,
  parameter int SCALE = 1,
  localparam int IW = (DELAY > 1) ? $clog2(DELAY) : 1,
  localparam int CW = $clog2(2 * DELAY)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  input  logic [15:0]   REAL_IN,
  input  logic [15:0]   IMAG_IN,
  output logic          OUT_VALID,
  output logic [15:0]   REAL_OUT,
  output logic [15:0]   IMAG_OUT,
  output logic          OUT_HALF,
  output logic [IW-1:0] OUT_IDX
);
  logic [31:0]   r_dl [DELAY];
  logic [CW-1:0] r_cnt;
  logic          r_primed;
  logic          w_bfly;
  logic [IW-1:0] w_idx;
  logic [15:0]   w_dr, w_di, w_sr, w_si, w_fr, w_fi;
  function automatic logic [15:0] bf(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [16:0] r;
    r = sub ? {a[15], a} - {b[15], b} : {a[15], a} + {b[15], b};
    return (SCALE != 0) ? r[16:1] : r[15:0];
  endfunction
  // 2*DELAY is a power of two, so the top counter bit is the phase and the low bits the wing index
  assign w_bfly = r_cnt[CW-1];
  assign w_idx  = (DELAY == 1) ? '0 : IW'(r_cnt);
  assign w_dr   = r_dl[DELAY-1][31:16];
  assign w_di   = r_dl[DELAY-1][15:0];
  assign w_sr   = bf(w_dr, REAL_IN, 1'b0);
  assign w_si   = bf(w_di, IMAG_IN, 1'b0);
  assign w_fr   = bf(w_dr, REAL_IN, 1'b1);
  assign w_fi   = bf(w_di, IMAG_IN, 1'b1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt     <= '0;
      r_primed  <= 1'b0;
      for (int i = 0; i < DELAY; i++) r_dl[i] <= '0;
      OUT_VALID <= 1'b0;
      REAL_OUT  <= '0;
      IMAG_OUT  <= '0;
      OUT_HALF  <= 1'b0;
      OUT_IDX   <= '0;
    end else if (IN_VALID) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_bfly && &r_cnt) r_primed <= 1'b1;
      for (int i = DELAY - 1; i > 0; i--) r_dl[i] <= r_dl[i-1];
      r_dl[0]   <= w_bfly ? {w_fr, w_fi} : {REAL_IN, IMAG_IN};
      OUT_VALID <= w_bfly | r_primed;
      REAL_OUT  <= w_bfly ? w_sr : w_dr;
      IMAG_OUT  <= w_bfly ? w_si : w_di;
      OUT_HALF  <= ~w_bfly;
      OUT_IDX   <= w_idx;
    end else begin
      OUT_VALID <= 1'b0;
    end
  end
endmodule
